counter_modn_updown_multi: RTL

Parametrised successor to the team's single-digit mod-10 up/down counter. It chains DIGITS modulo-MODULUS digits into one multi-digit up/down counter. Added features: synchronous load with range checking, a selectable wrap or saturate mode, a terminal-count flag and a registered carry/borrow pulse for cascading. It sits in the same counter testbench environment and is driven through an extended counter interface.

---
 rtl/counter_modn_updown_multi.sv | 119 +++++++++++
 1 files changed

// File: rtl/counter_modn_updown_multi.sv
// Multi-digit modulo-N up/down counter.
// DIGITS cascaded digits, each counting modulo MODULUS. Supports synchronous
// load with per-digit clamping, wrap or saturate at the ends, a combinational
// terminal-count flag and registered carry/load-error pulses.
module counter_modn_updown_multi #(
  parameter int MODULUS = 10,
  parameter int DIGITS  = 2,
  localparam int DW     = $clog2(MODULUS)
) (
  input  logic                 CLK,
  input  logic                 RESET_0,
  input  logic                 COUNTER_ACTIVE,
  input  logic                 UP_DOWN,
  input  logic                 LOAD,
  input  logic                 SATURATE,
  input  logic [DIGITS*DW-1:0] DATA_IN,
  output logic [DIGITS*DW-1:0] DATA_OUT,
  output logic                 TERMINAL_COUNT,
  output logic                 CARRY_OUT,
  output logic                 LOAD_ERROR
);

  // Largest legal digit value; arithmetic compares against it explicitly so
  // non-power-of-two bases never produce unused codes.
  localparam logic [DW-1:0] MAX_DIGIT = DW'(MODULUS - 1);

  logic [DIGITS*DW-1:0] count_q, count_d;
  logic                 carry_q, carry_d;
  logic                 load_error_q, load_error_d;
  logic                 all_max, all_zero;

  // Next-state computation: load (with clamp) beats counting, which beats hold.
  always_comb begin : next_state
    logic          chain;
    logic [DW-1:0] digit;
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    count_d      = count_q;
    carry_d      = 1'b0;
    load_error_d = 1'b0;
    chain        = 1'b1;
    digit        = '0;

    if (LOAD) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit = DATA_IN[i*DW +: DW];
        if (int'(digit) > MODULUS - 1) begin
          digit        = MAX_DIGIT;
          load_error_d = 1'b1;
        end
        count_d[i*DW +: DW] = digit;
      end
    end else if (COUNTER_ACTIVE) begin
      // Ripple carry/borrow through all digits within one cycle; chain stays
      // high while every lower digit rolled over.
      for (int i = 0; i < DIGITS; i++) begin
        digit = count_q[i*DW +: DW];
        if (chain) begin
          if (UP_DOWN) begin
            if (digit == MAX_DIGIT) begin
              digit = '0;
            end else begin
              digit = digit + DW'(1);
              chain = 1'b0;
            end
          end else begin
            if (digit == '0) begin
              digit = MAX_DIGIT;
            end else begin
              digit = digit - DW'(1);
              chain = 1'b0;
            end
          end
        end
        count_d[i*DW +: DW] = digit;
      end
      // chain still high means the whole counter rolled over.
      if (chain) begin
        if (SATURATE) begin
          count_d = count_q;
        end else begin
          carry_d = 1'b1;
        end
      end
    end
  end

  // Terminal-count detection from the current state.
  always_comb begin : terminal_detect
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[i*DW +: DW] != MAX_DIGIT) all_max  = 1'b0;
      if (count_q[i*DW +: DW] != '0)        all_zero = 1'b0;
    end
  end

  assign TERMINAL_COUNT = UP_DOWN ? all_max : all_zero;

  // State and pulse registers; reset clears everything immediately.
  always_ff @(posedge CLK or negedge RESET_0) begin
    if (!RESET_0) begin
      count_q      <= '0;
      carry_q      <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values, avoiding ordering-dependent simulation results.
      count_q      <= count_d;
      carry_q      <= carry_d;
      load_error_q <= load_error_d;
    end
  end

  assign DATA_OUT   = count_q;
  assign CARRY_OUT  = carry_q;
  assign LOAD_ERROR = load_error_q;

endmodule
